// File: rtl/strip_scheduler.sv
// Symbol scheduler feeding the byte striper: frames packets with STP/END/EDB,
// fills gaps with IDL and inserts periodic full rows of SKP between packets.
module strip_scheduler #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned BITS         = 8,
  parameter int unsigned SKP_INTERVAL = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [BITS-1:0]          in_data,
  input  logic                     in_last,
  input  logic                     in_abort,
  output logic                     in_ready,
  output logic [BITS-1:0]          d,
  output logic                     dk,
  output logic [$clog2(LANES)-1:0] slot,
  output logic                     err_underrun
);

  localparam int unsigned SW = $clog2(LANES);
  localparam int unsigned TW = $clog2(SKP_INTERVAL);

  localparam logic [BITS-1:0] SYM_STP = BITS'(8'hFB);
  localparam logic [BITS-1:0] SYM_END = BITS'(8'hFD);
  localparam logic [BITS-1:0] SYM_EDB = BITS'(8'hFE);
  localparam logic [BITS-1:0] SYM_SKP = BITS'(8'h1C);
  localparam logic [BITS-1:0] SYM_IDL = BITS'(8'h7C);

  localparam logic [SW-1:0] LAST_SLOT = SW'(LANES - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    DATA = 2'd2,
    PAD  = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   slot_cnt;
  logic [TW-1:0]   timer;
  logic            skp_pending;
  logic            abort;

  logic            slot_zero;
  logic            slot_last;
  logic            tmr_wrap;
  logic            skp_start;

  assign in_ready  = (state == DATA);
  assign slot_zero = (slot_cnt == '0);
  assign slot_last = (slot_cnt == LAST_SLOT);
  assign tmr_wrap  = (timer == TMR_LAST);
  // SKP takes priority over STP at the start of an idle row.
  assign skp_start = (state == IDLE) && slot_zero && skp_pending;

  // Slot counter, SKP timer and symbol selection; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      timer        <= '0;
      skp_pending  <= 1'b0;
      abort        <= 1'b0;
      d            <= SYM_IDL;
      dk           <= 1'b1;
      slot         <= '0;
      err_underrun <= 1'b0;
    end else begin
      slot         <= slot_cnt;
      slot_cnt     <= slot_last ? '0 : slot_cnt + SW'(1);
      timer        <= tmr_wrap ? '0 : timer + TW'(1);
      // A wrap coinciding with the first SKP of a row is a fresh request.
      skp_pending  <= tmr_wrap | (skp_pending & ~skp_start);
      err_underrun <= 1'b0;
      d            <= SYM_IDL;
      dk           <= 1'b1;

      case (state)
        IDLE: begin
          if (skp_start) begin
            d     <= SYM_SKP;
            state <= SKIP;
          end else if (slot_zero && in_valid) begin
            d     <= SYM_STP;
            dk    <= 1'b0;
            state <= DATA;
          end
        end
        SKIP: begin
          d <= SYM_SKP;
          if (slot_last) state <= IDLE;
        end
        DATA: begin
          if (in_valid) begin
            d <= in_data;
            if (in_last) begin
              abort <= in_abort;
              state <= PAD;
            end
          end else begin
            err_underrun <= 1'b1;
          end
        end
        PAD: begin
          if (slot_last) begin
            d     <= abort ? SYM_EDB : SYM_END;
            dk    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_scheduler.sv
// Directed bench for strip_scheduler (LANES=4, SKP_INTERVAL=16); expected
// symbols are hand-derived per cycle counted from reset release.
module tb_strip_scheduler;

  localparam int unsigned LANES        = 4;
  localparam int unsigned BITS         = 8;
  localparam int unsigned SKP_INTERVAL = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            in_valid = 1'b0;
  logic [BITS-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            in_abort = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] d;
  logic            dk;
  logic [1:0]      slot;
  logic            err_underrun;

  int checks = 0;
  int errors = 0;

  strip_scheduler #(
    .LANES(LANES), .BITS(BITS), .SKP_INTERVAL(SKP_INTERVAL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
    .in_ready(in_ready), .d(d), .dk(dk), .slot(slot), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Apply reset, check the asynchronous reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_abort = 1'b0;
    #1;
    chk({tag, ".rst.d"},    32'(d), 32'h7C);
    chk({tag, ".rst.dk"},   32'(dk), 32'd1);
    chk({tag, ".rst.slot"}, 32'(slot), 32'd0);
    chk({tag, ".rst.err"},  32'(err_underrun), 32'd0);
    chk({tag, ".rst.rdy"},  32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, check in_ready before the edge, check outputs after it.
  task automatic step(input bit v, input logic [7:0] dat, input bit l, input bit a,
                      input bit rdy, input logic [7:0] ed, input bit edk, input int es,
                      input bit eerr, input string tag);
    in_valid = v;
    in_data  = dat;
    in_last  = l;
    in_abort = a;
    #1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    chk({tag, ".d"},    32'(d), 32'(ed));
    chk({tag, ".dk"},   32'(dk), 32'(edk));
    chk({tag, ".slot"}, 32'(slot), 32'(es));
    chk({tag, ".err"},  32'(err_underrun), 32'(eerr));
  endtask

  initial begin
    #2;
    // Idle after reset: IDL on every slot.
    do_reset("idle");
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 0, 8'h7C, 1, i % 4, 0, "idle");

    // Two-byte packet: END directly after a last byte at slot LANES-2.
    do_reset("pa");
    step(1, 8'hA1, 0, 0, 0, 8'hFB, 0, 0, 0, "pa.stp");
    step(1, 8'hA1, 0, 0, 1, 8'hA1, 1, 1, 0, "pa.b1");
    step(1, 8'hA2, 1, 0, 1, 8'hA2, 1, 2, 0, "pa.b2");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "pa.end");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 0, 0, "pa.idl");

    // Three-byte packet: last byte at slot 3 needs three IDL of padding.
    do_reset("pb");
    step(1, 8'hB1, 0, 0, 0, 8'hFB, 0, 0, 0, "pb.stp");
    step(1, 8'hB1, 0, 0, 1, 8'hB1, 1, 1, 0, "pb.b1");
    step(1, 8'hB2, 0, 0, 1, 8'hB2, 1, 2, 0, "pb.b2");
    step(1, 8'hB3, 1, 0, 1, 8'hB3, 1, 3, 0, "pb.b3");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 0, 0, "pb.pad0");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 1, 0, "pb.pad1");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 2, 0, "pb.pad2");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "pb.end");

    // Aborted packet gives EDB; next packet starts at once and abort is not sticky;
    // IN_ABORT without IN_LAST is ignored.
    do_reset("pc");
    step(1, 8'hC1, 0, 0, 0, 8'hFB, 0, 0, 0, "pc.stp");
    step(1, 8'hC1, 0, 0, 1, 8'hC1, 1, 1, 0, "pc.b1");
    step(1, 8'hC2, 1, 1, 1, 8'hC2, 1, 2, 0, "pc.b2");
    step(1, 8'hD1, 0, 0, 0, 8'hFE, 0, 3, 0, "pc.edb");
    step(1, 8'hD1, 0, 0, 0, 8'hFB, 0, 0, 0, "pd.stp");
    step(1, 8'hD1, 0, 1, 1, 8'hD1, 1, 1, 0, "pd.b1");
    step(1, 8'hD2, 1, 0, 1, 8'hD2, 1, 2, 0, "pd.b2");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "pd.end");

    // Underrun inside a packet; IN_LAST with IN_VALID low is ignored.
    do_reset("ur");
    step(1, 8'hE1, 0, 0, 0, 8'hFB, 0, 0, 0, "ur.stp");
    step(1, 8'hE1, 0, 0, 1, 8'hE1, 1, 1, 0, "ur.b1");
    step(0, 8'h00, 1, 0, 1, 8'h7C, 1, 2, 1, "ur.gap0");
    step(0, 8'h00, 1, 0, 1, 8'h7C, 1, 3, 1, "ur.gap1");
    step(1, 8'hE2, 1, 0, 1, 8'hE2, 1, 0, 0, "ur.b2");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 1, 0, "ur.pad0");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 2, 0, "ur.pad1");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "ur.end");

    // Reset mid-packet: partial packet dropped, no END afterwards.
    do_reset("rm");
    step(1, 8'h51, 0, 0, 0, 8'hFB, 0, 0, 0, "rm.stp");
    step(1, 8'h51, 0, 0, 1, 8'h51, 1, 1, 0, "rm.b1");
    step(1, 8'h52, 0, 0, 1, 8'h52, 1, 2, 0, "rm.b2");
    do_reset("rm.mid");
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0, 8'h7C, 1, i, 0, "rm.post");

    // Back-to-back 2-byte packets; timer wraps at cycle 15, SKP row then STP.
    do_reset("skp");
    for (int p = 0; p < 4; p++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(2 * p);
      step(1, b, 0, 0, 0, 8'hFB, 0, 0, 0, "skp.stp");
      step(1, b, 0, 0, 1, b, 1, 1, 0, "skp.b1");
      step(1, b + 8'h01, 1, 0, 1, b + 8'h01, 1, 2, 0, "skp.b2");
      step(1, 8'hEE, 0, 0, 0, 8'hFD, 0, 3, 0, "skp.end");
    end
    for (int i = 0; i < 4; i++) step(1, 8'h30, 0, 0, 0, 8'h1C, 1, i, 0, "skp.row");
    step(1, 8'h30, 0, 0, 0, 8'hFB, 0, 0, 0, "skp.stp2");
    step(1, 8'h30, 1, 0, 1, 8'h30, 1, 1, 0, "skp.b3");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 2, 0, "skp.pad");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "skp.end2");

    // Long packet spanning the timer wrap: SKP waits until after END.
    do_reset("lp");
    step(1, 8'h40, 0, 0, 0, 8'hFB, 0, 0, 0, "lp.stp");
    for (int i = 0; i < 16; i++)
      step(1, 8'h40 + 8'(i), (i == 15), 0, 1, 8'h40 + 8'(i), 1, (1 + i) % 4, 0, "lp.data");
    step(1, 8'h60, 0, 0, 0, 8'h7C, 1, 1, 0, "lp.pad0");
    step(1, 8'h60, 0, 0, 0, 8'h7C, 1, 2, 0, "lp.pad1");
    step(1, 8'h60, 0, 0, 0, 8'hFD, 0, 3, 0, "lp.end");
    for (int i = 0; i < 4; i++) step(1, 8'h60, 0, 0, 0, 8'h1C, 1, i, 0, "lp.row");
    step(1, 8'h60, 0, 0, 0, 8'hFB, 0, 0, 0, "lp.stp2");
    step(1, 8'h60, 1, 0, 1, 8'h60, 1, 1, 0, "lp.b1");
    step(0, 8'h00, 0, 0, 0, 8'h7C, 1, 2, 0, "lp.pad2");
    step(0, 8'h00, 0, 0, 0, 8'hFD, 0, 3, 0, "lp.end2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strip_scheduler.md
# strip_scheduler

Symbol scheduler placed directly upstream of the byte striper. It accepts packet bytes over a valid/ready handshake and emits one symbol per clock, tagged with its lane slot, on the striper's D/DK inputs. Framing rules are enforced by construction:
- STP is placed only in lane 0.
- END/EDB is placed only in lane LANES-1.
- Gaps are filled with IDL.
- A full row of SKP is inserted periodically between packets.

## Interface
- LANES, 4: number of lanes striped; slot counter modulus. Legal range 2..8.
- BITS, 8: symbol width. Only 8 is supported.
- SKP_INTERVAL, 64: cycles between SKP requests. Must be ≥ 2*LANES.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  a packet byte is offered.
- IN_DATA  in  BITS  packet byte.
- IN_LAST  in  1  the offered byte is the final byte of the packet.
- IN_ABORT  in  1  sampled with IN_LAST; 1 closes the packet with EDB instead of END.
- IN_READY  out  1  the block accepts IN_DATA at this edge.
- D  out  BITS  symbol to the striper (registered).
- DK  out  1  0 for framing symbols (STP, END, EDB); 1 for data, IDL and SKP (registered).
- SLOT  out  clog2(LANES)  lane index of the current D (registered).
- ERR_UNDERRUN  out  1  one-cycle pulse: IN_VALID was low while inside a packet.

## Operation
- Symbol codes: STP 8'hFB, END 8'hFD, EDB 8'hFE, SKP 8'h1C, IDL 8'h7C.
- Internal slot counter `slot`:
  - Free-running 0..LANES-1, wrapping to 0.
  - On every edge: D/DK <= symbol chosen for `slot`; SLOT <= slot; slot <= slot+1 mod LANES.
- Transfer: a byte is consumed when IN_VALID && IN_READY at an edge. IN_READY = (state == DATA), combinational from state only.
- SKP timer:
  - Counts every cycle 0..SKP_INTERVAL-1, then wraps.
  - Sets skp_pending on wrap.
  - A wrap while skp_pending is already set leaves it set; requests are not queued.
  - skp_pending is cleared on the edge that emits the first SKP of a row.
- States:
  - IDLE
    - slot==0 and skp_pending: emit SKP, go to SKIP.
    - else slot==0 and IN_VALID: emit STP (DK=0), go to DATA. The STP edge consumes no byte.
    - otherwise: emit IDL.
    - SKP has priority over starting a packet.
  - SKIP: emit SKP (DK=1) for slots 1..LANES-1. At slot LANES-1, go to IDLE.
  - DATA
    - IN_VALID=1: emit IN_DATA (DK=1).
      - If IN_LAST=1: latch abort <= IN_ABORT and go to PAD.
    - IN_VALID=0: emit IDL (DK=1), pulse ERR_UNDERRUN, stay in DATA.
    - SKP is never inserted inside a packet; skp_pending waits.
  - PAD
    - slot != LANES-1: emit IDL.
    - slot == LANES-1: emit EDB if abort, else END (DK=0). Go to IDLE.
- Packet length is unbounded. The slot position of data bytes is whatever the counter gives.

## Timing
- Reset values (asynchronous):
  - D=8'h7C, DK=1, SLOT=0, ERR_UNDERRUN=0.
  - IN_READY=0, state IDLE, slot 0, SKP timer 0, skp_pending 0, abort 0.
- Latency:
  - A byte consumed at edge k appears on D after edge k, i.e. one cycle later, with the SLOT it occupies.
  - Earliest STP is at slot 0. First data byte is at slot 1.
- END placement after the last byte at slot s:
  - s == LANES-2: END directly, no padding.
  - otherwise: ((LANES-2-s) mod LANES) IDL symbols, then END.
- A new packet can start only at slot 0 following an END in slot LANES-1. There is no back-to-back STP within the same row.
- SKP row: exactly LANES consecutive SKP symbols, slots 0..LANES-1. It begins at the first IDLE slot-0 edge after skp_pending is set.
- Reset mid-packet: the partial packet is dropped and no END is emitted. The first post-reset symbol is IDL at slot 0.
- IN_LAST with IN_VALID low is ignored. IN_ABORT without IN_LAST is ignored.

## Test plan
- Reset, then idle for 8 cycles -> D=7C, DK=1 every cycle; SLOT sequence 0,1,2,3,0,1,2,3.
- LANES=4, 2-byte packet A1,A2 (last) offered at slot 0 -> D: FB(DK0,s0), A1(s1), A2(s2), FD(DK0,s3); IN_READY high exactly 2 cycles.
- 3-byte packet B1..B3 -> D: FB, B1, B2, B3(s3), 7C, 7C, 7C, FD(s3).
- Packet C1,C2 with IN_ABORT=1 on C2 -> FE (DK0) at s3 instead of FD.
- SKP_INTERVAL=16, IN_VALID held high continuously -> skp_pending wrap at cycle 15:
  - SKP row 1C×4 (DK1) emitted at the next IDLE slot 0.
  - STP deferred to the following row.
  - No 1C between any STP and END.
- IN_VALID dropped for 2 cycles mid-packet -> two 7C with DK=1 inside the packet, two ERR_UNDERRUN pulses, packet resumes; RESET_N asserted mid-packet -> D=7C, SLOT=0 immediately, no FD afterwards.
